// File: rtl/tqvp_stevej_feeder_pkg.sv
// Shared definitions for the watchdog feeder peripheral: register map, bit positions,
// FSM state type and the byte/half/word write-merge helpers.
package tqvp_stevej_feeder_pkg;

   localparam logic [5:0] ADDR_CTRL      = 6'h00;
   localparam logic [5:0] ADDR_PERIOD    = 6'h01;
   localparam logic [5:0] ADDR_WIDTH     = 6'h02;
   localparam logic [5:0] ADDR_ARM       = 6'h03;
   localparam logic [5:0] ADDR_STATUS    = 6'h04;
   localparam logic [5:0] ADDR_PAT_COUNT = 6'h05;
   localparam logic [5:0] ADDR_IRQ_CLR   = 6'h06;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_AUTO = 1;
   localparam int CTRL_INV  = 2;

   localparam int ST_ARMED   = 0;
   localparam int ST_MISSED  = 1;
   localparam int ST_FAULT   = 2;
   localparam int ST_PULSING = 3;

   typedef enum logic [1:0] {IDLE, RUN, PULSE} state_t;

   function automatic logic [31:0] write_mask(input logic [1:0] wn);
      case (wn)
         2'b00:   return 32'h0000_00FF;
         2'b01:   return 32'h0000_FFFF;
         2'b10:   return 32'hFFFF_FFFF;
         default: return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [31:0] merge_write(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [1:0]  wn);
      logic [31:0] m;
      m = write_mask(wn);
      return (old_v & ~m) | (new_v & m);
   endfunction

endpackage

// File: rtl/tqvp_stevej_watchdog_feeder.sv
// TinyQV peripheral driving periodic pat pulses to an external windowed watchdog;
// a pat is only sent when software re-armed the block within the current period.
module tqvp_stevej_watchdog_feeder
   import tqvp_stevej_feeder_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);

   state_t      state_q, state_d;
   logic [31:0] counter_q, counter_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] period_q, period_d;
   logic [15:0] width_q, width_d;
   logic [31:0] pat_count_q, pat_count_d;
   logic        armed_q, armed_d;
   logic        missed_q, missed_d;
   logic        ext_fault_q, ext_fault_d;
   logic        pat_q, pat_d;

   logic        wr, enabled, arm_wr, take_pat, miss, pulsing;
   logic [31:0] p_eff, w_eff, w_min1;
   logic        unused_inputs;

   assign unused_inputs = ^{ui_in[7:2], ui_in[0], data_read_n};

   assign wr      = (data_write_n != 2'b11);
   assign enabled = ctrl_q[CTRL_EN];
   assign arm_wr  = wr && (address == ADDR_ARM) && enabled;

   // At least one idle cycle per period, so the pulse is clamped to P-1.
   assign p_eff  = (period_q < 32'd2) ? 32'd2 : period_q;
   assign w_min1 = (width_q == 16'd0) ? 32'd1 : {16'b0, width_q};
   assign w_eff  = (w_min1 > p_eff - 32'd1) ? p_eff - 32'd1 : w_min1;

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      ctrl_d      = ctrl_q;
      period_d    = period_q;
      width_d     = width_q;
      pat_count_d = pat_count_q;
      armed_d     = armed_q;
      missed_d    = missed_q;
      ext_fault_d = ext_fault_q;

      if (wr && address == ADDR_CTRL) begin
         ctrl_d[CTRL_EN] = data_in[CTRL_EN];
         if (!enabled) begin
            ctrl_d[CTRL_AUTO] = data_in[CTRL_AUTO];
            ctrl_d[CTRL_INV]  = data_in[CTRL_INV];
         end
      end
      if (wr && address == ADDR_PERIOD && !enabled)
         period_d = merge_write(period_q, data_in, data_write_n);
      if (wr && address == ADDR_WIDTH && !enabled)
         width_d = 16'(merge_write({16'b0, width_q}, data_in, data_write_n));

      if (wr && address == ADDR_PAT_COUNT) pat_count_d = '0;
      if (take_pat)                        pat_count_d = pat_count_d + 32'd1;

      if (arm_wr)            armed_d = 1'b1;
      if (take_pat)          armed_d = 1'b0;
      if (!ctrl_d[CTRL_EN])  armed_d = 1'b0;

      // Event sets are applied after clears so a coincident set wins.
      if (wr && address == ADDR_IRQ_CLR && data_in[0]) missed_d    = 1'b0;
      if (wr && address == ADDR_IRQ_CLR && data_in[1]) ext_fault_d = 1'b0;
      if (miss)                                        missed_d    = 1'b1;
      if (enabled && !ui_in[1])                        ext_fault_d = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      take_pat  = 1'b0;
      miss      = 1'b0;
      if (!ctrl_d[CTRL_EN]) begin
         state_d   = IDLE;
         counter_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d   = RUN;
               counter_d = '0;
            end
            RUN, PULSE: begin
               counter_d = counter_q + 32'd1;
               if (state_q == PULSE && counter_q == w_eff - 32'd1) state_d = RUN;
               if (counter_q == p_eff - 32'd1) begin
                  counter_d = '0;
                  if (armed_q || arm_wr || ctrl_q[CTRL_AUTO]) begin
                     state_d  = PULSE;
                     take_pat = 1'b1;
                  end else begin
                     miss = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      pulsing = (state_q == PULSE);
      pat_d   = (state_d == PULSE) ^ ctrl_d[CTRL_INV];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         counter_q   <= '0;
         ctrl_q      <= '0;
         period_q    <= '0;
         width_q     <= '0;
         pat_count_q <= '0;
         armed_q     <= 1'b0;
         missed_q    <= 1'b0;
         ext_fault_q <= 1'b0;
         pat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         ctrl_q      <= ctrl_d;
         period_q    <= period_d;
         width_q     <= width_d;
         pat_count_q <= pat_count_d;
         armed_q     <= armed_d;
         missed_q    <= missed_d;
         ext_fault_q <= ext_fault_d;
         pat_q       <= pat_d;
      end
   end

   always_comb begin
      data_out = '0;
      case (address)
         ADDR_CTRL:      data_out = {29'b0, ctrl_q};
         ADDR_PERIOD:    data_out = period_q;
         ADDR_WIDTH:     data_out = {16'b0, width_q};
         ADDR_ARM:       data_out = {31'b0, armed_q};
         ADDR_STATUS: begin
            data_out[ST_ARMED]   = armed_q;
            data_out[ST_MISSED]  = missed_q;
            data_out[ST_FAULT]   = ext_fault_q;
            data_out[ST_PULSING] = pulsing;
         end
         ADDR_PAT_COUNT: data_out = pat_count_q;
         default:        data_out = '0;
      endcase
   end

   assign uo_out         = {2'b00, ext_fault_q, missed_q, armed_q, ctrl_q[CTRL_EN], pat_q, 1'b0};
   assign data_ready     = 1'b1;
   assign user_interrupt = missed_q | ext_fault_q;

endmodule

// File: tb/tb_tqvp_stevej_watchdog_feeder.sv
// Directed bench for the watchdog feeder: register vector table, then cycle-exact
// sequences for pat timing, misses, faults, clamping and coincident events.
module tb_tqvp_stevej_watchdog_feeder;
   import tqvp_stevej_feeder_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ui_in;
   logic [7:0]  uo_out;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;
   logic        user_interrupt;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
      logic [1:0]  wn;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs [0:16];
   logic [31:0] pat_v;

   tqvp_stevej_watchdog_feeder dut (
      .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
      .address(address), .data_in(data_in), .data_write_n(data_write_n),
      .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
      .user_interrupt(user_interrupt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
      address      = a;
      data_in      = d;
      data_write_n = wn;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      drive(a, d, 2'b10);
      tick();
      data_write_n = 2'b11;
   endtask

   task automatic rd(input logic [5:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = data_out;
   endtask

   function automatic logic [31:0] span(input int lo, input int hi);
      logic [31:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   initial begin
      logic [31:0] d;

      rst_n = 1'b0; ui_in = 8'h02; address = '0; data_in = '0;
      data_write_n = 2'b11; data_read_n = 2'b11;
      tick(); tick();
      check("rst uo_out", {24'b0, uo_out}, 32'h0);
      check("rst irq", {31'b0, user_interrupt}, 32'h0);
      check("data_ready", {31'b0, data_ready}, 32'h1);
      rst_n = 1'b1;
      tick();

      // Register vectors, all applied while the block is disabled.
      vecs[0]  = '{6'h00, 32'h0,         2'b11, 32'h0,         "rst CTRL"};
      vecs[1]  = '{6'h01, 32'h0,         2'b11, 32'h0,         "rst PERIOD"};
      vecs[2]  = '{6'h02, 32'h0,         2'b11, 32'h0,         "rst WIDTH"};
      vecs[3]  = '{6'h03, 32'h0,         2'b11, 32'h0,         "rst ARM"};
      vecs[4]  = '{6'h04, 32'h0,         2'b11, 32'h0,         "rst STATUS"};
      vecs[5]  = '{6'h05, 32'h0,         2'b11, 32'h0,         "rst PAT_COUNT"};
      vecs[6]  = '{6'h06, 32'h0,         2'b11, 32'h0,         "rst IRQ_CLR"};
      vecs[7]  = '{6'h3F, 32'h0,         2'b11, 32'h0,         "unmapped"};
      vecs[8]  = '{6'h01, 32'h1234_5678, 2'b10, 32'h1234_5678, "PERIOD word"};
      vecs[9]  = '{6'h01, 32'hFFFF_FFAB, 2'b00, 32'h1234_56AB, "PERIOD byte"};
      vecs[10] = '{6'h01, 32'hFFFF_CDEF, 2'b01, 32'h1234_CDEF, "PERIOD half"};
      vecs[11] = '{6'h02, 32'hFFFF_1234, 2'b10, 32'h0000_1234, "WIDTH word"};
      vecs[12] = '{6'h02, 32'h0000_00AA, 2'b00, 32'h0000_12AA, "WIDTH byte"};
      vecs[13] = '{6'h00, 32'h0000_0006, 2'b00, 32'h0000_0006, "CTRL auto+inv"};
      vecs[14] = '{6'h00, 32'h0000_0000, 2'b10, 32'h0000_0000, "CTRL clear"};
      vecs[15] = '{6'h03, 32'h0000_0001, 2'b10, 32'h0000_0000, "ARM while disabled"};
      vecs[16] = '{6'h04, 32'h0,         2'b11, 32'h0,         "STATUS idle"};
      for (int i = 0; i <= 16; i++) begin
         if (vecs[i].wn != 2'b11) begin
            drive(vecs[i].addr, vecs[i].data, vecs[i].wn);
            tick();
            data_write_n = 2'b11;
         end
         rd(vecs[i].addr, d);
         check(vecs[i].name, d, vecs[i].exp);
      end

      // Auto mode, P=10, W=3.
      wr(ADDR_PERIOD, 32'd10); wr(ADDR_WIDTH, 32'd3); wr(ADDR_CTRL, 32'h2);
      wr(ADDR_CTRL, 32'h3);
      pat_v = '0;
      for (int k = 1; k <= 25; k++) begin
         pat_v[k] = uo_out[1];
         if (k == 1) check("A enabled", {31'b0, uo_out[2]}, 32'h1);
         if (k == 12) begin rd(ADDR_PAT_COUNT, d); check("A patcnt k12", d, 32'd1); end
         if (k == 22) begin rd(ADDR_PAT_COUNT, d); check("A patcnt k22", d, 32'd2); end
         tick();
      end
      check("A pat window", pat_v, span(11, 13) | span(21, 23));
      wr(ADDR_CTRL, 32'h0);
      wr(ADDR_PAT_COUNT, 32'h0);

      // Armed mode, P=10: first period missed, arm at k19 gives pulse 21..23.
      wr(ADDR_CTRL, 32'h1);
      pat_v = '0;
      for (int k = 1; k <= 25; k++) begin
         pat_v[k] = uo_out[1];
         if (k == 10) check("B missed k10", {31'b0, uo_out[4]}, 32'h0);
         if (k == 11) check("B missed k11", {31'b0, uo_out[4]}, 32'h1);
         if (k == 11) check("B irq k11", {31'b0, user_interrupt}, 32'h1);
         if (k == 20) check("B armed k20", {31'b0, uo_out[3]}, 32'h1);
         if (k == 22) begin rd(ADDR_STATUS, d); check("B status k22", d, 32'hA); end
         if (k == 24) check("B irq k24", {31'b0, user_interrupt}, 32'h1);
         if (k == 25) check("B irq cleared", {31'b0, user_interrupt}, 32'h0);
         if (k == 19) drive(ADDR_ARM, 32'h1, 2'b10);
         if (k == 24) drive(ADDR_IRQ_CLR, 32'h1, 2'b10);
         tick();
         data_write_n = 2'b11;
      end
      check("B pat window", pat_v, span(21, 23));
      wr(ADDR_CTRL, 32'h0);

      // Clamp: PERIOD=1, WIDTH=0 -> P=2, W=1.
      wr(ADDR_PERIOD, 32'd1); wr(ADDR_WIDTH, 32'd0); wr(ADDR_CTRL, 32'h2);
      wr(ADDR_CTRL, 32'h3);
      pat_v = '0;
      for (int k = 1; k <= 12; k++) begin
         pat_v[k] = uo_out[1];
         tick();
      end
      check("C toggle", pat_v, 32'h0000_0AA8);
      wr(ADDR_CTRL, 32'h0);
      wr(ADDR_PAT_COUNT, 32'h0);

      // Clamp W to P-1 (PERIOD=8, WIDTH=50), then disable mid-pulse.
      wr(ADDR_PERIOD, 32'd8); wr(ADDR_WIDTH, 32'd50); wr(ADDR_CTRL, 32'h2);
      wr(ADDR_CTRL, 32'h3);
      pat_v = '0;
      for (int k = 1; k <= 28; k++) begin
         pat_v[k] = uo_out[1];
         if (k == 27) check("D armed k27", {31'b0, uo_out[3]}, 32'h1);
         if (k == 28) begin
            check("D enabled off", {31'b0, uo_out[2]}, 32'h0);
            check("D armed off", {31'b0, uo_out[3]}, 32'h0);
            rd(ADDR_PAT_COUNT, d);
            check("D patcnt held", d, 32'd3);
         end
         if (k == 2)  drive(ADDR_PERIOD, 32'h99, 2'b10);
         if (k == 26) drive(ADDR_ARM, 32'h1, 2'b10);
         if (k == 27) drive(ADDR_CTRL, 32'h2, 2'b10);
         tick();
         data_write_n = 2'b11;
      end
      check("D pat window", pat_v, span(9, 15) | span(17, 23) | span(25, 27));
      rd(ADDR_PERIOD, d);
      check("D period locked", d, 32'd8);

      // Non-auto P=4: coincident miss/clear, fault stickiness, separate clears.
      wr(ADDR_PERIOD, 32'd4); wr(ADDR_CTRL, 32'h0);
      wr(ADDR_CTRL, 32'h1);
      for (int k = 1; k <= 16; k++) begin
         if (k == 5)  check("E missed k5", {31'b0, uo_out[4]}, 32'h1);
         if (k == 9)  check("E set wins", {31'b0, uo_out[4]}, 32'h1);
         if (k == 11) check("E missed clr", {31'b0, uo_out[4]}, 32'h0);
         if (k == 12) check("E fault pre", {31'b0, uo_out[5]}, 32'h0);
         if (k == 13) check("E fault set", {31'b0, uo_out[5]}, 32'h1);
         if (k == 15) check("E fault sticky", {31'b0, uo_out[5]}, 32'h1);
         if (k == 16) begin
            check("E fault clr", {31'b0, uo_out[5]}, 32'h0);
            check("E missed kept", {31'b0, uo_out[4]}, 32'h1);
         end
         if (k == 8)  drive(ADDR_IRQ_CLR, 32'h1, 2'b10);
         if (k == 10) drive(ADDR_IRQ_CLR, 32'h1, 2'b10);
         if (k == 12) ui_in = 8'h00;
         if (k == 15) drive(ADDR_IRQ_CLR, 32'h2, 2'b10);
         tick();
         data_write_n = 2'b11;
         ui_in = 8'h02;
      end
      wr(ADDR_CTRL, 32'h0);

      // PAT_COUNT clear coinciding with a pat decision.
      wr(ADDR_CTRL, 32'h2); wr(ADDR_PAT_COUNT, 32'h0);
      wr(ADDR_CTRL, 32'h3);
      for (int k = 1; k <= 10; k++) begin
         if (k == 5) begin rd(ADDR_PAT_COUNT, d); check("F patcnt k5", d, 32'd1); end
         if (k == 9) begin rd(ADDR_PAT_COUNT, d); check("F clr+inc", d, 32'd1); end
         if (k == 8) drive(ADDR_PAT_COUNT, 32'h0, 2'b10);
         tick();
         data_write_n = 2'b11;
      end
      wr(ADDR_CTRL, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
